// File: rtl/data_ram_wbuf_pkg.sv
// ============================================================================
// Module      : data_ram_wbuf_pkg
// Description : Shared types and helpers for the posted-write data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_ram_wbuf_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int SEL_W      = 4;
    localparam int WORD_MAX_W = 30;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [REG_BUS_W-1:0]  reg_bus_t;
    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [WORD_MAX_W-1:0] word_t;

    typedef struct packed {
        logic     valid;
        word_t    word;
        sel_t     mask;
        reg_bus_t data;
    } wbuf_entry_t;

    // Byte-lane overlay: lanes with mask=1 take the new value.
    function automatic reg_bus_t merge_bytes(input reg_bus_t old_w,
                                             input reg_bus_t new_w,
                                             input sel_t     mask);
        reg_bus_t r;
        r = old_w;
        for (int b = 0; b < SEL_W; b++) begin
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_wbuf_wbuf.sv
// ============================================================================
// Module      : data_wbuf
// Description : Posted-write FIFO with tail coalescing, drain handshake and
//               byte-granular read forwarding (oldest to youngest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_wbuf
    import data_ram_wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] word,
    input  sel_t                  wr_sel,
    input  reg_bus_t              wr_data,
    input  logic                  drain_ok,
    input  reg_bus_t              lk_base,
    output reg_bus_t              lk_data,
    output logic                  tail_hit,
    output logic                  full,
    output logic                  empty,
    output logic                  drain,
    output logic [ADDR_WIDTH-1:0] drain_word,
    output sel_t                  drain_mask,
    output reg_bus_t              drain_data
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WBUF_DEPTH - 1);
    localparam logic [PTR_W:0]   DEPTH_X  = (PTR_W+1)'(WBUF_DEPTH);

    wbuf_entry_t       entries [WBUF_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  tail_last;
    logic [CNT_W-1:0]  count;
    word_t             word_x;
    logic [PTR_W:0]    fwd_j;
    logic [PTR_W-1:0]  fwd_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign word_x     = word_t'(word);
    assign tail_last  = (tail == '0) ? LAST_PTR : tail - 1'b1;
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(WBUF_DEPTH));
    assign tail_hit   = !empty && entries[tail_last].valid && (entries[tail_last].word == word_x);
    assign drain      = !empty && drain_ok;
    assign drain_word = entries[head].word[ADDR_WIDTH-1:0];
    assign drain_mask = entries[head].mask;
    assign drain_data = entries[head].data;

    wire unused_head = &{1'b0, entries[head].valid, entries[head].word};

    // Walk from head so younger entries overwrite older bytes.
    always_comb begin
        lk_data = lk_base;
        fwd_j   = '0;
        fwd_idx = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            fwd_j = {1'b0, head} + (PTR_W+1)'(i);
            if (fwd_j >= DEPTH_X) fwd_j = fwd_j - DEPTH_X;
            fwd_idx = fwd_j[PTR_W-1:0];
            if (entries[fwd_idx].valid && (entries[fwd_idx].word == word_x))
                lk_data = merge_bytes(lk_data, entries[fwd_idx].data, entries[fwd_idx].mask);
        end
    end

    // wr_en and drain are mutually exclusive by construction in the parent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) entries[i] <= '0;
        end else if (wr_en && tail_hit) begin
            entries[tail_last].data <= merge_bytes(entries[tail_last].data, wr_data, wr_sel);
            entries[tail_last].mask <= entries[tail_last].mask | wr_sel;
        end else if (wr_en) begin
            entries[tail] <= '{valid: 1'b1, word: word_x, mask: wr_sel, data: wr_data};
            tail          <= next_ptr(tail);
            count         <= count + 1'b1;
        end else if (drain) begin
            entries[head].valid <= 1'b0;
            head                <= next_ptr(head);
            count               <= count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_ram_wbuf.sv
// ============================================================================
// Module      : data_ram_wbuf
// Description : OpenMIPS data RAM with posted-write buffer and MEM stall.
//               Optional DATA_RAM_ERR_EN adds an access-error output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_wbuf
    import data_ram_wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall,
    output logic        wbuf_empty
`ifdef DATA_RAM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    reg_bus_t              mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word;
    logic                  acc_err;
    logic                  write_req;
    logic                  wr_en;
    logic                  tail_hit;
    logic                  full;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] drain_word;
    sel_t                  drain_mask;
    reg_bus_t              drain_data;
    reg_bus_t              fwd_data;

    assign word = addr[ADDR_WIDTH+1:2];

`ifdef DATA_RAM_ERR_EN
    logic sel_legal;
    always_comb begin
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
            default:                   sel_legal = 1'b0;
        endcase
    end
    assign acc_err = ce && (((addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
                            ((addr[1:0] != 2'b00) && (sel == 4'b1111)) ||
                            !sel_legal);
    assign err = acc_err;
`else
    assign acc_err = 1'b0;
    wire unused_addr = &{1'b0, addr[1:0], addr[31:ADDR_WIDTH+2]};
`endif

    // A full buffer stalls a new-word write while the head drains in its place.
    assign write_req = ce && we && !acc_err;
    assign stall     = write_req && full && !tail_hit;
    assign wr_en     = write_req && !stall;

    data_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .word       (word),
        .wr_sel     (sel),
        .wr_data    (data_i),
        .drain_ok   (!ce || stall),
        .lk_base    (mem[word]),
        .lk_data    (fwd_data),
        .tail_hit   (tail_hit),
        .full       (full),
        .empty      (wbuf_empty),
        .drain      (drain),
        .drain_word (drain_word),
        .drain_mask (drain_mask),
        .drain_data (drain_data)
    );

    assign data_o = (ce && !we && !acc_err) ? fwd_data : ZERO_WORD;

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (drain_mask[b]) mem[drain_word][8*b +: 8] <= drain_data[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire
